alu_operand_stage: RTL and testbench

//  Execute-entry stage directly upstream of the ALU. It registers decoded operands and funct3 behind a

---
 rtl/alu_operand_stage.sv | 194 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Execute-entry operand stage: captures decoded operands behind a two-entry skid buffer,
// forwards EX/MEM and MEM/WB results into them, and presents the final ALU inputs.
module alu_operand_stage #(
    parameter int XLEN     = 32,
    parameter int REG_BITS = 5
) (
    input  logic                in_clk,
    input  logic                in_rst,
    input  logic                in_flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_BITS-1:0] in_rs1_idx,
    input  logic [REG_BITS-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    input  logic [XLEN-1:0]     in_imm,
    input  logic                in_use_imm,
    input  logic [2:0]          in_funct3,
    input  logic [REG_BITS-1:0] in_rd,
    input  logic                in_fwd_ex_en,
    input  logic [REG_BITS-1:0] in_fwd_ex_rd,
    input  logic [XLEN-1:0]     in_fwd_ex_data,
    input  logic                in_fwd_wb_en,
    input  logic [REG_BITS-1:0] in_fwd_wb_rd,
    input  logic [XLEN-1:0]     in_fwd_wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data1,
    output logic [XLEN-1:0]     out_data2,
    output logic [2:0]          out_select,
    output logic [REG_BITS-1:0] out_rd,
    output logic [1:0]          buf_state
);

    // Handshake: a transfer happens on any rising edge where valid and ready are both high;
    // in_ready depends only on the registered occupancy, never on out_ready.
    localparam int SHAMT_BITS = $clog2(XLEN);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HEAD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_BITS-1:0] rs1_idx;
        logic [REG_BITS-1:0] rs2_idx;
        logic                use_imm;
        logic [XLEN-1:0]     op1;
        logic [XLEN-1:0]     op2;
        logic [2:0]          funct3;
        logic [REG_BITS-1:0] rd;
    } entry_t;

    state_t state;
    state_t state_next;
    entry_t head;
    entry_t skid;
    entry_t head_next;
    entry_t skid_next;
    entry_t captured;
    entry_t head_snoop;
    entry_t skid_snoop;
    logic   in_fire;
    logic   out_fire;
    logic   shift_op;

    // EX wins over WB; x0 is hardwired and never takes a forwarded value.
    function automatic logic [XLEN-1:0] resolve(
        input logic [REG_BITS-1:0] idx,
        input logic [XLEN-1:0]     fallback,
        input logic                ex_en,
        input logic [REG_BITS-1:0] ex_rd,
        input logic [XLEN-1:0]     ex_data,
        input logic                wb_en,
        input logic [REG_BITS-1:0] wb_rd,
        input logic [XLEN-1:0]     wb_data
    );
        if (idx == '0) begin
            return fallback;
        end else if (ex_en && (ex_rd == idx)) begin
            return ex_data;
        end else if (wb_en && (wb_rd == idx)) begin
            return wb_data;
        end
        return fallback;
    endfunction

    assign in_fire  = in_valid && (state != FULL);
    assign out_fire = (state != EMPTY) && out_ready;

    always_comb begin
        captured         = '0;
        captured.rs1_idx = in_rs1_idx;
        captured.rs2_idx = in_rs2_idx;
        captured.use_imm = in_use_imm;
        captured.funct3  = in_funct3;
        captured.rd      = in_rd;
        captured.op1     = resolve(in_rs1_idx, in_rs1_data,
                                   in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                   in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
        captured.op2     = in_use_imm ? in_imm
                         : resolve(in_rs2_idx, in_rs2_data,
                                   in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                   in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
    end

    // Held entries keep watching the result buses so a stalled consumer picks up late producers.
    always_comb begin
        head_snoop     = head;
        skid_snoop     = skid;
        head_snoop.op1 = resolve(head.rs1_idx, head.op1,
                                 in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                 in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
        skid_snoop.op1 = resolve(skid.rs1_idx, skid.op1,
                                 in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                 in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
        if (!head.use_imm) begin
            head_snoop.op2 = resolve(head.rs2_idx, head.op2,
                                     in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                     in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
        end
        if (!skid.use_imm) begin
            skid_snoop.op2 = resolve(skid.rs2_idx, skid.op2,
                                     in_fwd_ex_en, in_fwd_ex_rd, in_fwd_ex_data,
                                     in_fwd_wb_en, in_fwd_wb_rd, in_fwd_wb_data);
        end
    end

    always_comb begin
        state_next = state;
        head_next  = (state != EMPTY) ? head_snoop : head;
        skid_next  = (state == FULL) ? skid_snoop : skid;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = HEAD;
                    head_next  = captured;
                end
            end
            HEAD: begin
                if (in_fire && !out_fire) begin
                    state_next = FULL;
                    skid_next  = captured;
                end else if (in_fire && out_fire) begin
                    head_next  = captured;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next = HEAD;
                    head_next  = skid_snoop;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (in_flush) begin
            state_next = EMPTY;
            head_next  = head;
            skid_next  = skid;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            head <= head_next;
            skid <= skid_next;
        end
    end

    // Shifts only consume the low shamt bits, so the rest are cleared before the ALU sees them.
    assign shift_op   = (head.funct3 == 3'b001) || (head.funct3 == 3'b101);
    assign out_valid  = (state != EMPTY);
    assign in_ready   = (state != FULL);
    assign out_data1  = head.op1;
    assign out_data2  = shift_op ? {{(XLEN-SHAMT_BITS){1'b0}}, head.op2[SHAMT_BITS-1:0]} : head.op2;
    assign out_select = head.funct3;
    assign out_rd     = head.rd;
    assign buf_state  = state;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: an occupancy-queue model checked every cycle,
// plus literal expectations for reset, streaming, forwarding, stall snooping, shifts and flush.
module tb_alu_operand_stage;

    logic        in_clk;
    logic        in_rst;
    logic        in_flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rs2_idx;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_fwd_ex_en;
    logic [4:0]  in_fwd_ex_rd;
    logic [31:0] in_fwd_ex_data;
    logic        in_fwd_wb_en;
    logic [4:0]  in_fwd_wb_rd;
    logic [31:0] in_fwd_wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [2:0]  out_select;
    logic [4:0]  out_rd;
    logic [1:0]  buf_state;

    alu_operand_stage #(.XLEN(32), .REG_BITS(5)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_funct3(in_funct3), .in_rd(in_rd),
        .in_fwd_ex_en(in_fwd_ex_en), .in_fwd_ex_rd(in_fwd_ex_rd), .in_fwd_ex_data(in_fwd_ex_data),
        .in_fwd_wb_en(in_fwd_wb_en), .in_fwd_wb_rd(in_fwd_wb_rd), .in_fwd_wb_data(in_fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data1(out_data1), .out_data2(out_data2), .out_select(out_select), .out_rd(out_rd),
        .buf_state(buf_state)
    );

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [2:0]  f3;
        logic [4:0]  rd;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] seen_d1[$];
    ent_t        m_ent;
    ent_t        c_ent;
    bit          live = 1'b0;
    bit          zeros_exp = 1'b0;
    bit          take;
    bit          give;
    int          checks = 0;
    int          errors = 0;

    // clock / reset
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] bus_pick(input logic [4:0] idx, input logic [31:0] dflt);
        if (idx != 5'd0 && in_fwd_ex_en && in_fwd_ex_rd == idx) return in_fwd_ex_data;
        if (idx != 5'd0 && in_fwd_wb_en && in_fwd_wb_rd == idx) return in_fwd_wb_data;
        return dflt;
    endfunction

    function automatic logic [31:0] alu_b(input logic [2:0] f3, input logic [31:0] v);
        if (f3 == 3'b001 || f3 == 3'b101) return v & 32'h0000_001F;
        return v;
    endfunction

    // model: an in-order queue of at most two entries
    always @(posedge in_clk) begin
        if (in_rst) begin
            exp_q.delete();
            zeros_exp = 1'b1;
            live = 1'b1;
        end else if (in_flush) begin
            exp_q.delete();
        end else begin
            take = in_valid && (exp_q.size() < 2);
            give = out_ready && (exp_q.size() > 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                m_ent = exp_q[i];
                m_ent.v1 = bus_pick(m_ent.rs1, m_ent.v1);
                if (!m_ent.use_imm) m_ent.v2 = bus_pick(m_ent.rs2, m_ent.v2);
                exp_q[i] = m_ent;
            end
            if (give) void'(exp_q.pop_front());
            if (take) begin
                m_ent.rs1 = in_rs1_idx;
                m_ent.rs2 = in_rs2_idx;
                m_ent.use_imm = in_use_imm;
                m_ent.v1 = bus_pick(in_rs1_idx, in_rs1_data);
                m_ent.v2 = in_use_imm ? in_imm : bus_pick(in_rs2_idx, in_rs2_data);
                m_ent.f3 = in_funct3;
                m_ent.rd = in_rd;
                exp_q.push_back(m_ent);
                zeros_exp = 1'b0;
            end
        end
    end

    // compare process
    always @(negedge in_clk) begin
        if (live) begin
            if (out_valid && out_ready) seen_d1.push_back(out_data1);
            check("out_valid", {31'd0, out_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
            check("in_ready", {31'd0, in_ready}, (exp_q.size() < 2) ? 32'd1 : 32'd0);
            check("buf_state", {30'd0, buf_state}, exp_q.size());
            if (exp_q.size() > 0) begin
                c_ent = exp_q[0];
                check("out_data1", out_data1, c_ent.v1);
                check("out_data2", out_data2, alu_b(c_ent.f3, c_ent.v2));
                check("out_select", {29'd0, out_select}, {29'd0, c_ent.f3});
                check("out_rd", {27'd0, out_rd}, {27'd0, c_ent.rd});
            end else if (zeros_exp) begin
                check("zero_data1", out_data1, 32'd0);
                check("zero_data2", out_data2, 32'd0);
                check("zero_select", {29'd0, out_select}, 32'd0);
                check("zero_rd", {27'd0, out_rd}, 32'd0);
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send(input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui,
                        input logic [2:0] f3, input logic [4:0] rd);
        bit ok;
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_rs1_idx = r1; in_rs1_data = d1;
        in_rs2_idx = r2; in_rs2_data = d2;
        in_imm = imm; in_use_imm = ui; in_funct3 = f3; in_rd = rd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge in_clk);
            ok = in_ready;
            @(posedge in_clk);
            #1;
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
        end
    endtask

    task automatic drain_one();
        @(posedge in_clk);
        #1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic buses_off();
        in_fwd_ex_en = 1'b0; in_fwd_ex_rd = 5'd0; in_fwd_ex_data = 32'd0;
        in_fwd_wb_en = 1'b0; in_fwd_wb_rd = 5'd0; in_fwd_wb_data = 32'd0;
    endtask

    int n0;

    initial begin
        in_rst = 1'b1; in_flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        in_rs1_idx = 5'd1; in_rs2_idx = 5'd2; in_rs1_data = 32'h1234; in_rs2_data = 32'h5678;
        in_imm = 32'd0; in_use_imm = 1'b0; in_funct3 = 3'b000; in_rd = 5'd9;
        buses_off();

        // reset held two cycles with in_valid high
        step(); step();
        in_rst = 1'b0; in_valid = 1'b0;
        @(negedge in_clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data1", out_data1, 32'd0);
        check("rst_data2", out_data2, 32'd0);
        check("rst_select", {29'd0, out_select}, 32'd0);
        check("rst_rd", {27'd0, out_rd}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // back-to-back stream
        step();
        out_ready = 1'b1;
        n0 = seen_d1.size();
        for (int i = 0; i < 4; i++) send(5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 1'b0, 3'b000, 5'(10 + i));
        repeat (3) step();
        check("stream_count", seen_d1.size() - n0, 32'd4);
        for (int i = 0; i < 4; i++) check("stream_d1", seen_d1[n0 + i], 32'd5);
        out_ready = 1'b0;

        // capture forwarding: EX beats WB, x0 ignored, WB alone on rs2
        in_fwd_ex_en = 1'b1; in_fwd_ex_rd = 5'd3; in_fwd_ex_data = 32'hAA;
        in_fwd_wb_en = 1'b1; in_fwd_wb_rd = 5'd3; in_fwd_wb_data = 32'hBB;
        send(5'd3, 32'd1, 5'd4, 32'd2, 32'd0, 1'b0, 3'b000, 5'd1);
        buses_off();
        @(negedge in_clk);
        check("fwd_ex_prio", out_data1, 32'hAA);
        drain_one();
        in_fwd_ex_en = 1'b1; in_fwd_ex_rd = 5'd0; in_fwd_ex_data = 32'hAA;
        in_fwd_wb_en = 1'b1; in_fwd_wb_rd = 5'd0; in_fwd_wb_data = 32'hBB;
        send(5'd0, 32'd1, 5'd0, 32'd2, 32'd0, 1'b0, 3'b000, 5'd1);
        buses_off();
        @(negedge in_clk);
        check("fwd_x0_d1", out_data1, 32'd1);
        check("fwd_x0_d2", out_data2, 32'd2);
        drain_one();
        in_fwd_ex_en = 1'b1; in_fwd_ex_rd = 5'd10; in_fwd_ex_data = 32'hDD;
        in_fwd_wb_en = 1'b1; in_fwd_wb_rd = 5'd9; in_fwd_wb_data = 32'hCC;
        send(5'd8, 32'h11, 5'd9, 32'h22, 32'd0, 1'b0, 3'b000, 5'd2);
        buses_off();
        @(negedge in_clk);
        check("fwd_wb_rs2", out_data2, 32'hCC);
        check("fwd_none_rs1", out_data1, 32'h11);
        drain_one();

        // stall, snoop into head and skid, then release in order
        send(5'd6, 32'h10, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd3);
        send(5'd7, 32'h20, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd4);
        @(negedge in_clk);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_head_d1", out_data1, 32'h10);
        @(posedge in_clk); #1;
        in_valid = 1'b1; in_rs1_idx = 5'd8; in_rs1_data = 32'h30; in_rs2_idx = 5'd0;
        in_rs2_data = 32'd0; in_use_imm = 1'b0; in_funct3 = 3'b000; in_rd = 5'd5;
        step(); step();
        in_fwd_ex_en = 1'b1; in_fwd_ex_rd = 5'd6; in_fwd_ex_data = 32'h55;
        in_fwd_wb_en = 1'b1; in_fwd_wb_rd = 5'd7; in_fwd_wb_data = 32'h66;
        step();
        buses_off();
        @(negedge in_clk);
        check("snoop_head_d1", out_data1, 32'h55);
        n0 = seen_d1.size();
        @(posedge in_clk); #1;
        out_ready = 1'b1;
        send(5'd8, 32'h30, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd5);
        repeat (4) step();
        check("stall_count", seen_d1.size() - n0, 32'd3);
        if (seen_d1.size() - n0 == 3) begin
            check("stall_order0", seen_d1[n0], 32'h55);
            check("stall_order1", seen_d1[n0 + 1], 32'h66);
            check("stall_order2", seen_d1[n0 + 2], 32'h30);
        end
        out_ready = 1'b0;

        // shift masking on operand 2
        send(5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFE3, 1'b1, 3'b001, 5'd6);
        @(negedge in_clk);
        check("sll_d2", out_data2, 32'd3);
        check("sll_sel", {29'd0, out_select}, 32'd1);
        drain_one();
        send(5'd0, 32'd0, 5'd0, 32'd0, 32'hFFFF_FFE3, 1'b1, 3'b000, 5'd6);
        @(negedge in_clk);
        check("add_imm_d2", out_data2, 32'hFFFF_FFE3);
        drain_one();
        send(5'd0, 32'd0, 5'd12, 32'h1234_5678, 32'd0, 1'b0, 3'b101, 5'd7);
        @(negedge in_clk);
        check("srl_rs2_d2", out_data2, 32'h18);
        drain_one();

        // flush while full with a same-cycle input
        send(5'd1, 32'hA1, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd8);
        send(5'd1, 32'hA2, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd9);
        in_valid = 1'b1; in_rs1_data = 32'h99; in_flush = 1'b1;
        step();
        in_flush = 1'b0; in_valid = 1'b0;
        @(negedge in_clk);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        n0 = seen_d1.size();
        @(posedge in_clk); #1;
        out_ready = 1'b1;
        repeat (4) step();
        check("flush_no_emit", seen_d1.size() - n0, 32'd0);
        out_ready = 1'b0;

        // reset while full
        send(5'd2, 32'h77, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd1);
        send(5'd2, 32'h78, 5'd0, 32'd0, 32'd0, 1'b0, 3'b000, 5'd2);
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        @(negedge in_clk);
        check("rst_full_valid", {31'd0, out_valid}, 32'd0);
        check("rst_full_d1", out_data1, 32'd0);
        check("rst_full_ready", {31'd0, in_ready}, 32'd1);

        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
